fetch_instr_buffer: RTL and testbench



---
 rtl/fetch_instr_buffer_pkg.sv | 18 +
 rtl/fetch_lane_compact.sv | 26 ++
 rtl/fetch_instr_buffer.sv | 92 +++++++++
 tb/tb_fetch_instr_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_instr_buffer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_instr_buffer_pkg -- frontend fetch-buffer widths and entry type (rev 1.0)
// ============================================================================
package fetch_instr_buffer_pkg;

  localparam int unsigned VLEN            = 64;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned LANE_W          = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int unsigned LANE_CNT_W      = $clog2(INSTR_PER_FETCH + 1);

  typedef struct packed {
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_lane_compact.sv
`default_nettype none
// ============================================================================
// fetch_lane_compact -- packs valid fetch lanes into consecutive write offsets (rev 1.0)
// ============================================================================
module fetch_lane_compact
  import fetch_instr_buffer_pkg::*;
(
  input  logic [INSTR_PER_FETCH-1:0]             valid,
  output logic [INSTR_PER_FETCH-1:0][LANE_W-1:0] offset,
  output logic [LANE_CNT_W-1:0]                  popcnt
);

  // Each lane lands after all lower-numbered valid lanes.
  always_comb begin
    logic [LANE_CNT_W-1:0] acc;
    acc    = '0;
    offset = '0;
    for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
      offset[i] = LANE_W'(acc);
      acc       = acc + LANE_CNT_W'(valid[i]);
    end
    popcnt = acc;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_instr_buffer.sv
`default_nettype none
// ============================================================================
// fetch_instr_buffer -- circular buffer between re-aligner and decode (rev 1.0)
// ============================================================================
module fetch_instr_buffer
  import fetch_instr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [INSTR_PER_FETCH-1:0]        valid_i,
  input  logic [INSTR_PER_FETCH*VLEN-1:0]   addr_i,
  input  logic [INSTR_PER_FETCH*32-1:0]     instr_i,
  output logic                              ready_o,
  output logic                              dropped_o,
  output logic                              valid_o,
  output logic [VLEN-1:0]                   addr_o,
  output logic [31:0]                       instr_o,
  output logic                              is_compressed_o,
  input  logic                              ready_i,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t                          mem [DEPTH];
  logic [PTR_W-1:0]                      rd_ptr;
  logic [PTR_W-1:0]                      wr_ptr;
  logic [CNT_W-1:0]                      count;
  logic                                  dropped;
  logic                                  push;
  logic                                  pop;
  logic [INSTR_PER_FETCH-1:0][LANE_W-1:0] lane_off;
  logic [LANE_CNT_W-1:0]                 lane_cnt;

  fetch_lane_compact u_compact (
    .valid  (valid_i),
    .offset (lane_off),
    .popcnt (lane_cnt)
  );

  // Only depends on registered occupancy, so upstream sees no path from valid_i.
  assign ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(INSTR_PER_FETCH);
  assign push    = ready_o & ~flush_i;
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
        if (valid_i[i]) begin
          mem[wr_ptr + PTR_W'(lane_off[i])] <= '{addr:  addr_i[i*VLEN +: VLEN],
                                                 instr: instr_i[i*32 +: 32]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(lane_cnt);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count + (push ? CNT_W'(lane_cnt) : CNT_W'(0)) - CNT_W'(pop);
      dropped <= ~ready_o & (|valid_i);
    end
  end

  assign addr_o          = mem[rd_ptr].addr;
  assign instr_o         = mem[rd_ptr].instr;
  assign is_compressed_o = (instr_o[1:0] != 2'b11);
  assign count_o         = count;
  assign dropped_o       = dropped;

endmodule
`default_nettype wire

// File: tb/tb_fetch_instr_buffer.sv
`default_nettype none
// ============================================================================
// tb_fetch_instr_buffer -- directed and randomized checks against a queue model (rev 1.0)
// ============================================================================
module tb_fetch_instr_buffer;
  import fetch_instr_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int IPF   = int'(INSTR_PER_FETCH);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush_i = 1'b0;
  logic [IPF-1:0]          valid_i = '0;
  logic [IPF*VLEN-1:0]     addr_i = '0;
  logic [IPF*32-1:0]       instr_i = '0;
  logic                    ready_i = 1'b0;
  logic                    ready_o, dropped_o, valid_o, is_compressed_o;
  logic [VLEN-1:0]         addr_o;
  logic [31:0]             instr_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  typedef struct {
    logic [VLEN-1:0] a;
    logic [31:0]     i;
  } ent_t;

  ent_t q[$];
  bit   m_dropped = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i),
    .addr_i(addr_i), .instr_i(instr_i), .ready_o(ready_o), .dropped_o(dropped_o),
    .valid_o(valid_o), .addr_o(addr_o), .instr_o(instr_o),
    .is_compressed_o(is_compressed_o), .ready_i(ready_i), .count_o(count_o)
  );

  task automatic drive(input logic [1:0] v, input logic [VLEN-1:0] a0, input logic [VLEN-1:0] a1,
                       input logic [31:0] i0, input logic [31:0] i1, input logic rdy, input logic fl);
    valid_i = v;
    addr_i  = {a1, a0};
    instr_i = {i1, i0};
    ready_i = rdy;
    flush_i = fl;
  endtask

  // Advance the reference queue with the current inputs, then clock the DUT.
  task automatic tick();
    int sz = q.size();
    bit mready = (DEPTH - sz) >= IPF;
    if (flush_i) begin
      q.delete();
      m_dropped = 0;
    end else begin
      if (sz != 0 && ready_i) void'(q.pop_front());
      if (mready)
        for (int l = 0; l < IPF; l++)
          if (valid_i[l]) q.push_back('{addr_i[l*VLEN +: VLEN], instr_i[l*32 +: 32]});
      m_dropped = !mready && (valid_i != '0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    m_dropped = 0;
    #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if (dropped_o !== 1'b0) begin fails++; $display("FAIL reset_dropped got %b exp 0", dropped_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 4'd0)
      begin fails++; $display("FAIL idle_after_reset got v=%b r=%b c=%0d exp v=0 r=1 c=0", valid_o, ready_o, count_o); end
  endtask

  task automatic test_dual_push();
    drive(2'b11, 64'h1000, 64'h1002, 32'h0001, 32'h4501, 1'b0, 1'b0);
    tick();
    tests++; if (valid_o !== 1'b1 || addr_o !== 64'h1000)
      begin fails++; $display("FAIL dual_head got v=%b a=%h exp v=1 a=1000", valid_o, addr_o); end
    tests++; if (is_compressed_o !== 1'b1 || count_o !== 4'd2)
      begin fails++; $display("FAIL dual_cmp_count got c=%b n=%0d exp c=1 n=2", is_compressed_o, count_o); end
    drive(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    tests++; if (valid_o !== 1'b1 || addr_o !== 64'h1002 || instr_o !== 32'h4501)
      begin fails++; $display("FAIL dual_second got v=%b a=%h i=%h exp v=1 a=1002 i=4501", valid_o, addr_o, instr_o); end
    tick();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL dual_empty got %b exp 0", valid_o); end
  endtask

  task automatic test_compaction();
    drive(2'b10, 64'hdead, 64'h2006, 32'hffff_ffff, 32'h00A0_0093, 1'b0, 1'b0);
    tick();
    tests++; if (count_o !== 4'd1 || addr_o !== 64'h2006 || instr_o !== 32'h00A0_0093 || is_compressed_o !== 1'b0)
      begin fails++; $display("FAIL compact got n=%0d a=%h i=%h c=%b exp n=1 a=2006 i=00a00093 c=0",
                              count_o, addr_o, instr_o, is_compressed_o); end
    drive(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_full_wrap();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 64'h4000 + 64'(4*k), 64'h4002 + 64'(4*k), 32'h0003, 32'h0003, 1'b0, 1'b0);
      tick();
      tests++; if (count_o !== 4'(2*(k+1)) || ready_o !== (k < 3))
        begin fails++; $display("FAIL fill_%0d got n=%0d r=%b exp n=%0d r=%b", k, count_o, ready_o, 2*(k+1), k < 3); end
    end
    drive(2'b11, 64'h9990, 64'h9992, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tests++; if (dropped_o !== 1'b1 || count_o !== 4'd8)
      begin fails++; $display("FAIL overflow got d=%b n=%0d exp d=1 n=8", dropped_o, count_o); end
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tests++; if (dropped_o !== 1'b0) begin fails++; $display("FAIL drop_pulse got %b exp 0", dropped_o); end
    ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tests++; if (valid_o !== 1'b1 || addr_o !== 64'h4000 + 64'(2*n))
        begin fails++; $display("FAIL drain_%0d got v=%b a=%h exp v=1 a=%h", n, valid_o, addr_o, 64'h4000 + 64'(2*n)); end
      tick();
    end
    tests++; if (valid_o !== 1'b0 || count_o !== 4'd0)
      begin fails++; $display("FAIL drained got v=%b n=%0d exp v=0 n=0", valid_o, count_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 64'h5000 + 64'(4*k), 64'h5002 + 64'(4*k), 32'h0001, 32'h0001, 1'b0, 1'b0);
      tick();
    end
    drive(2'b11, 64'h5100, 64'h5102, 32'h0001, 32'h0001, 1'b1, 1'b0);
    tick();
    tests++; if (count_o !== 4'd7 || addr_o !== 64'h5002)
      begin fails++; $display("FAIL simul got n=%0d a=%h exp n=7 a=5002", count_o, addr_o); end
    drive(2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) begin
      logic [VLEN-1:0] exp_a;
      exp_a = (n < 5) ? 64'h5002 + 64'(2*n) : 64'h5100 + 64'(2*(n-5));
      tests++; if (valid_o !== 1'b1 || addr_o !== exp_a)
        begin fails++; $display("FAIL simul_drain_%0d got v=%b a=%h exp v=1 a=%h", n, valid_o, addr_o, exp_a); end
      tick();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_flush();
    drive(2'b11, 64'h6000, 64'h6002, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b11, 64'h6004, 64'h6006, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b01, 64'h6008, 64'h0,    32'h0, 32'h0, 1'b0, 1'b0); tick();
    tests++; if (count_o !== 4'd5) begin fails++; $display("FAIL pre_flush got n=%0d exp 5", count_o); end
    drive(2'b11, 64'h7000, 64'h7002, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    tests++; if (count_o !== 4'd0 || valid_o !== 1'b0 || dropped_o !== 1'b0 || ready_o !== 1'b1)
      begin fails++; $display("FAIL flush got n=%0d v=%b d=%b r=%b exp n=0 v=0 d=0 r=1",
                              count_o, valid_o, dropped_o, ready_o); end
    drive(2'b01, 64'h3000, 64'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    tick();
    tests++; if (valid_o !== 1'b1 || addr_o !== 64'h3000)
      begin fails++; $display("FAIL post_flush got v=%b a=%h exp v=1 a=3000", valid_o, addr_o); end
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 64'h8000, 64'h8002, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    q.delete();
    m_dropped = 0;
    #1;
    tests++; if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b1)
      begin fails++; $display("FAIL async_reset got n=%0d v=%b r=%b exp n=0 v=0 r=1", count_o, valid_o, ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      logic [IPF-1:0]  v;
      logic [IPF*VLEN-1:0] a;
      logic [IPF*32-1:0] ins;
      v = IPF'($urandom_range(0, 3));
      for (int l = 0; l < IPF; l++) begin
        a[l*VLEN +: VLEN] = {32'h0, $urandom} & ~64'h1;
        ins[l*32 +: 32]   = $urandom_range(0, 1) ? {16'h0, 16'($urandom) & 16'hfffc} | 32'(1)
                                                 : $urandom | 32'h3;
      end
      valid_i = v;
      addr_i  = a;
      instr_i = ins;
      ready_i = ($urandom_range(0, 2) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      tick();
      tests++; if (valid_o !== (q.size() != 0))
        begin fails++; $display("FAIL rand_valid cyc %0d got %b exp %b", n, valid_o, q.size() != 0); end
      tests++; if (count_o !== 4'(q.size()))
        begin fails++; $display("FAIL rand_count cyc %0d got %0d exp %0d", n, count_o, q.size()); end
      tests++; if (ready_o !== ((DEPTH - q.size()) >= IPF))
        begin fails++; $display("FAIL rand_ready cyc %0d got %b", n, ready_o); end
      tests++; if (dropped_o !== m_dropped)
        begin fails++; $display("FAIL rand_dropped cyc %0d got %b exp %b", n, dropped_o, m_dropped); end
      if (q.size() != 0) begin
        tests++; if (addr_o !== q[0].a || instr_o !== q[0].i)
          begin fails++; $display("FAIL rand_head cyc %0d got a=%h i=%h exp a=%h i=%h", n, addr_o, instr_o, q[0].a, q[0].i); end
        tests++; if (is_compressed_o !== (q[0].i[1:0] != 2'b11))
          begin fails++; $display("FAIL rand_cmp cyc %0d got %b", n, is_compressed_o); end
      end
    end
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_compaction();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
